id_ex_pipeline_reg: RTL

//  Decode->Execute pipeline register of the 5-stage RISC-V core. Captures the main-decoder
//  and ALU-decoder control (incl. 3-bit ALUControl) plus register-file operands and

---
 rtl/id_ex_pipeline_reg.sv | 125 ++++++++++++
 1 files changed

// File: rtl/id_ex_pipeline_reg.sv
// Decode->Execute pipeline register with a 1-cycle D->E latency, plus a saturating count of flush bubbles.
// StallE holds the whole E stage and FlushE loads a bubble; flush beats stall and reset beats both.
module id_ex_pipeline_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             ValidD,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic [2:0]       ALUControlD,
  input  logic             ALUSrcD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  output logic             ValidE,
  output logic             RegWriteE,
  output logic [1:0]       ResultSrcE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             BranchE,
  output logic [2:0]       ALUControlE,
  output logic             ALUSrcE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic [CNT_W-1:0] BubbleCnt
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm_ext;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } ex_stage_t;

  ex_stage_t        ex_q, ex_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (FlushE) begin
      ex_d = '0;
      if (bubble_cnt_q != '1) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end else if (!StallE) begin
      ex_d.valid       = ValidD;
      ex_d.result_src  = ResultSrcD;
      ex_d.alu_control = ALUControlD;
      ex_d.alu_src     = ALUSrcD;
      ex_d.rd1         = RD1D;
      ex_d.rd2         = RD2D;
      ex_d.pc          = PCD;
      ex_d.pc_plus4    = PCPlus4D;
      ex_d.imm_ext     = ImmExtD;
      ex_d.rs1         = Rs1D;
      ex_d.rs2         = Rs2D;
      ex_d.rd          = RdD;
      // An empty slot keeps its fields but must not write state or redirect the PC.
      ex_d.reg_write   = RegWriteD & ValidD;
      ex_d.mem_write   = MemWriteD & ValidD;
      ex_d.jump        = JumpD & ValidD;
      ex_d.branch      = BranchD & ValidD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ValidE      = ex_q.valid;
  assign RegWriteE   = ex_q.reg_write;
  assign ResultSrcE  = ex_q.result_src;
  assign MemWriteE   = ex_q.mem_write;
  assign JumpE       = ex_q.jump;
  assign BranchE     = ex_q.branch;
  assign ALUControlE = ex_q.alu_control;
  assign ALUSrcE     = ex_q.alu_src;
  assign RD1E        = ex_q.rd1;
  assign RD2E        = ex_q.rd2;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc_plus4;
  assign ImmExtE     = ex_q.imm_ext;
  assign Rs1E        = ex_q.rs1;
  assign Rs2E        = ex_q.rs2;
  assign RdE         = ex_q.rd;
  assign BubbleCnt   = bubble_cnt_q;

endmodule
